// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit between an execute
// stage and a RAM/IO bus.
//   req_*          : request handshake (valid/ready), read/write/io flags, byte address
//   ex_in          : execute result, used as write data or as the pass-through result
//   rsp_*          : response handshake, data, timeout error flag
//   bus_*          : shared bus address/data and ack
//   ram_*/io_*     : bus strobes, exactly one high per ACCESS cycle
// Requests with neither re nor we complete in one cycle with ex_in as result.
// Bus accesses wait for bus_ack for at most TIMEOUT cycles.
module mem_access_unit #(
  parameter int DW      = 8,
  parameter int AW      = 16,
  parameter int BAW     = 6,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_re,
  input  logic           req_we,
  input  logic           req_io,
  input  logic [AW-1:0]  req_addr,
  input  logic [DW-1:0]  ex_in,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_err,
  output logic [BAW-1:0] bus_adr,
  output logic [DW-1:0]  bus_dout,
  input  logic [DW-1:0]  bus_din,
  input  logic           bus_ack,
  output logic           ram_re,
  output logic           ram_we,
  output logic           io_re,
  output logic           io_we
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          re;
    logic          we;
    logic          io;
  } req_t;

  // Last ACCESS cycle that may still end without an ack.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  req_t          rq;
  logic [7:0]    wait_cnt;
  logic [DW-1:0] rsp_data_nxt;
  logic          rsp_err_nxt;
  logic          load;
  logic          dec, io_sel, acc;

  // Low data addresses 0x20..0x5F alias the IO space.
  assign dec    = (rq.addr[AW-1:7] == '0) && (rq.addr[6] ^ rq.addr[5]);
  assign io_sel = rq.io | dec;
  assign acc    = (state == ACCESS);

  // Strobes come only from state and latched request, so reset drops them at once.
  // A request with both re and we set is a write.
  assign ram_re = acc & ~io_sel & rq.re & ~rq.we;
  assign ram_we = acc & ~io_sel & rq.we;
  assign io_re  = acc &  io_sel & rq.re & ~rq.we;
  assign io_we  = acc &  io_sel & rq.we;

  assign bus_dout  = (acc && rq.we) ? rq.data : '0;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);

  // Aliased IO addresses fold 0x20..0x5F down onto 0x00..0x3F.
  always_comb begin
    bus_adr = rq.addr[BAW-1:0];
    if (dec && !rq.io) begin
      bus_adr      = '0;
      bus_adr[5:0] = {rq.addr[6], rq.addr[4:0]};
    end
  end

  always_comb begin
    state_nxt    = state;
    rsp_data_nxt = rsp_data;
    rsp_err_nxt  = rsp_err;
    load         = 1'b0;
    unique case (state)
      IDLE: if (req_valid) begin
        load = 1'b1;
        if (req_re || req_we) begin
          state_nxt = ACCESS;
        end else begin
          state_nxt    = DONE;
          rsp_data_nxt = ex_in;
          rsp_err_nxt  = 1'b0;
        end
      end
      ACCESS: begin
        // An ack in the final wait cycle beats the timeout.
        if (bus_ack) begin
          state_nxt    = DONE;
          rsp_data_nxt = rq.we ? rq.data : bus_din;
          rsp_err_nxt  = 1'b0;
        end else if (wait_cnt == TO_LAST) begin
          state_nxt    = DONE;
          rsp_data_nxt = '0;
          rsp_err_nxt  = 1'b1;
        end
      end
      DONE: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rq       <= '0;
      wait_cnt <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rsp_data <= rsp_data_nxt;
      rsp_err  <= rsp_err_nxt;
      if (load) begin
        rq       <= {req_addr, ex_in, req_re, req_we, req_io};
        wait_cnt <= '0;
      end else if (acc && !bus_ack) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: each transaction is turned into a list of
// expected per-cycle output frames (strobe cycles, then response cycles);
// one negedge process compares the DUT against the frame queue, idle
// expectations when the queue is empty.
module tb_mem_access_unit;
  localparam int DW = 8, AW = 16, BAW = 6, TIMEOUT = 15;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 0, req_re = 0, req_we = 0, req_io = 0, rsp_ready = 0, bus_ack = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] ex_in = '0, bus_din = '0;
  logic req_ready, rsp_valid, rsp_err, ram_re, ram_we, io_re, io_we;
  logic [DW-1:0] rsp_data, bus_dout;
  logic [BAW-1:0] bus_adr;

  mem_access_unit #(.DW(DW), .AW(AW), .BAW(BAW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_re(req_re), .req_we(req_we), .req_io(req_io), .req_addr(req_addr),
    .ex_in(ex_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .bus_adr(bus_adr),
    .bus_dout(bus_dout), .bus_din(bus_din), .bus_ack(bus_ack),
    .ram_re(ram_re), .ram_we(ram_we), .io_re(io_re), .io_we(io_we));

  always #5 clk = ~clk;

  // stb order: {ram_re, ram_we, io_re, io_we}
  typedef struct {
    logic [3:0]     stb;
    logic           chk_adr;
    logic [BAW-1:0] adr;
    logic [DW-1:0]  dout;
    logic           rv;
    logic [DW-1:0]  rd;
    logic           err;
    logic           rr;
  } frame_t;

  frame_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the expected frame queue.
  always @(negedge clk) begin
    frame_t f;
    if (chk_en) begin
      if (exp_q.size() > 0) f = exp_q.pop_front();
      else f = '{stb: 4'b0, chk_adr: 1'b0, adr: '0, dout: '0, rv: 1'b0, rd: '0, err: 1'b0, rr: 1'b1};
      chk("strobes", {28'd0, ram_re, ram_we, io_re, io_we}, {28'd0, f.stb});
      chk("req_ready", {31'd0, req_ready}, {31'd0, f.rr});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, f.rv});
      chk("bus_dout", {24'd0, bus_dout}, {24'd0, f.dout});
      if (f.chk_adr) chk("bus_adr", {26'd0, bus_adr}, {26'd0, f.adr});
      if (f.rv) begin
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, f.rd});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, f.err});
      end
    end
  end

  // Observation counters used by the directed scenarios.
  int c_ram_re = 0, c_ram_we = 0, c_io_re = 0, c_io_we = 0;
  logic [BAW-1:0] last_adr = '0;
  logic [DW-1:0]  last_dout = '0, last_rd = '0;
  logic           last_err = 1'b0;
  logic           clr_mon = 1'b0;
  always @(negedge clk) begin
    if (clr_mon) begin
      c_ram_re = 0; c_ram_we = 0; c_io_re = 0; c_io_we = 0;
    end else begin
      c_ram_re += int'(ram_re); c_ram_we += int'(ram_we);
      c_io_re  += int'(io_re);  c_io_we  += int'(io_we);
      if (ram_re | ram_we | io_re | io_we) begin last_adr = bus_adr; last_dout = bus_dout; end
      if (rsp_valid) begin last_rd = rsp_data; last_err = rsp_err; end
    end
  end

  task automatic clear_mon();
    clr_mon = 1'b1;
    @(negedge clk);
    #1 clr_mon = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issue one request. ack_at: access cycle on which bus_ack is given
  // (> TIMEOUT means never). bp: cycles rsp_ready stays low.
  task automatic do_txn(input logic [AW-1:0] a, input logic re, input logic we,
                        input logic io, input logic [DW-1:0] ex, input int ack_at,
                        input int bp, input logic [DW-1:0] din_ack);
    logic dec, ios, acc;
    logic [BAW-1:0] adr;
    logic [DW-1:0] rd;
    logic err;
    int n;
    frame_t f;
    dec = (a < 16'h80) && (((a >> 6) & 1) != ((a >> 5) & 1));
    ios = io || dec;
    if (dec && !io) adr = BAW'(((a >> 1) & 16'h20) + (a & 16'h1F));
    else            adr = BAW'(a % (1 << BAW));
    acc = re || we;
    n = !acc ? 0 : (ack_at <= TIMEOUT ? ack_at : TIMEOUT);
    if (!acc)                   begin rd = ex; err = 1'b0; end
    else if (ack_at <= TIMEOUT) begin rd = we ? ex : din_ack; err = 1'b0; end
    else                        begin rd = '0; err = 1'b1; end

    req_valid = 1'b1; req_addr = a; req_re = re; req_we = we; req_io = io; ex_in = ex;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = AW'($urandom); ex_in = DW'($urandom);
    for (int k = 0; k < n; k++) begin
      f = '{stb: ios ? (we ? 4'b0001 : 4'b0010) : (we ? 4'b0100 : 4'b1000),
            chk_adr: 1'b1, adr: adr, dout: we ? ex : '0, rv: 1'b0, rd: '0, err: 1'b0, rr: 1'b0};
      exp_q.push_back(f);
    end
    for (int j = 0; j <= bp; j++) begin
      f = '{stb: 4'b0, chk_adr: 1'b0, adr: '0, dout: '0, rv: 1'b1, rd: rd, err: err, rr: 1'b0};
      exp_q.push_back(f);
    end
    for (int k = 1; k <= n; k++) begin
      bus_ack = (k == ack_at);
      bus_din = (k == ack_at) ? din_ack : DW'($urandom);
      rsp_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    // Response phase: a new request is offered but must not be taken.
    for (int j = 0; j <= bp; j++) begin
      bus_ack = 1'($urandom); bus_din = DW'($urandom);
      req_valid = 1'($urandom); req_addr = AW'($urandom);
      req_re = 1'($urandom); req_we = 1'($urandom); ex_in = DW'($urandom);
      rsp_ready = (j == bp);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b0; bus_ack = 1'($urandom);
  endtask

  initial begin
    // Reset state.
    #3;
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rst rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst strobes", {28'd0, ram_re, ram_we, io_re, io_we}, 32'd0);
    chk("rst bus_adr", {26'd0, bus_adr}, 32'd0);
    chk("rst bus_dout", {24'd0, bus_dout}, 32'd0);
    #9 rst_n = 1'b1; chk_en = 1'b1;

    // Pass-through accepted on the first edge after reset release.
    do_txn(16'h0000, 0, 0, 0, 8'h5A, 1, 0, 8'h00);
    chk("pt strobes", 32'(c_ram_re + c_ram_we + c_io_re + c_io_we), 32'd0);
    chk("pt rsp_data", {24'd0, last_rd}, 32'h5A);

    // RAM read acked on the 4th access cycle.
    clear_mon();
    do_txn(16'h0123, 1, 0, 0, 8'h11, 4, 0, 8'hC3);
    chk("ramrd ram_re cycles", 32'(c_ram_re), 32'd4);
    chk("ramrd bus_adr", {26'd0, last_adr}, 32'h23);
    chk("ramrd rsp_data", {24'd0, last_rd}, 32'hC3);
    chk("ramrd rsp_err", {31'd0, last_err}, 32'd0);

    // Aliased IO write, immediate ack: 0x45 folds to IO address 0x25.
    clear_mon();
    do_txn(16'h0045, 0, 1, 0, 8'h77, 1, 0, 8'h00);
    chk("iowr io_we cycles", 32'(c_io_we), 32'd1);
    chk("iowr ram_we cycles", 32'(c_ram_we), 32'd0);
    chk("iowr bus_adr", {26'd0, last_adr}, 32'h25);
    chk("iowr bus_dout", {24'd0, last_dout}, 32'h77);

    // Timeout, then ack in the last allowed cycle.
    clear_mon();
    do_txn(16'h0123, 1, 0, 0, 8'h00, TIMEOUT + 1, 0, 8'h00);
    chk("to ram_re cycles", 32'(c_ram_re), 32'd15);
    chk("to rsp_err", {31'd0, last_err}, 32'd1);
    chk("to rsp_data", {24'd0, last_rd}, 32'd0);
    clear_mon();
    do_txn(16'h0123, 1, 0, 0, 8'h00, TIMEOUT, 0, 8'h9E);
    chk("ack15 ram_re cycles", 32'(c_ram_re), 32'd15);
    chk("ack15 rsp_err", {31'd0, last_err}, 32'd0);
    chk("ack15 rsp_data", {24'd0, last_rd}, 32'h9E);

    // Back-pressure on the response.
    do_txn(16'h0000, 0, 0, 0, 8'hA5, 1, 5, 8'h00);
    do_txn(16'h0200, 1, 1, 1, 8'h3C, 2, 5, 8'h00);

    // Reset in the middle of an IO read.
    chk_en = 1'b0;
    req_valid = 1'b1; req_addr = 16'h0045; req_re = 1; req_we = 0; req_io = 0;
    @(posedge clk); #1;
    req_valid = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;
    chk("midrst io_re before", {31'd0, io_re}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst io_re after", {31'd0, io_re}, 32'd0);
    chk("midrst req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    #1;
    chk("rel req_ready", {31'd0, req_ready}, 32'd1);
    chk("rel rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      logic [AW-1:0] a;
      a = ($urandom % 2) ? AW'($urandom_range(0, 255)) : AW'($urandom);
      do_txn(a, 1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom),
             $urandom_range(1, TIMEOUT + 2), $urandom_range(0, 3), DW'($urandom));
      repeat ($urandom_range(0, 2)) begin
        bus_ack = 1'($urandom); rsp_ready = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    repeat (3) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
